fp_add_controller: RTL and testbench
====================================

# fp_add_controller

Multi-cycle sequencer for the floating-point adder. Accepts two `fp_t` operands over a valid/ready handshake and steps them through compare/swap, iterative alignment, add/subtract and iterative normalization. It returns one `fp_t` result over a second valid/ready handshake. It sits between the operand source and the result consumer, and replaces the single-cycle align path with a one-bit-per-cycle shifter under FSM control.

## Interface
- `MAX_ALIGN`, default `FRAC_W`: cap on alignment shifts; any larger exponent difference flushes the small fraction to zero.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operands `a`/`b` are valid.
- `in_ready` out 1: block can accept operands.
- `a`, `b` in `fp_t`: operands {sign, exp[3:0], frac[FRAC_W-1:0]}.
- `out_valid` out 1: `result`/`overflow` are valid.
- `out_ready` in 1: consumer takes the result.
- `result` out `fp_t`: sum.
- `overflow` out 1: result saturated.
- `busy` out 1: state is not IDLE.

## Operation
- Number format: value = (-1)^sign · frac · 2^exp. There is no hidden bit. The normalized form is frac[MSB]=1 or frac==0. Exp is unsigned 4-bit.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `a`/`b` and go to COMPARE.
- **COMPARE** (1 cycle)
  - big = operand with larger exp. On equal exp, big = the larger frac. On full tie, big = `a`.
  - count = min(big.exp - small.exp, MAX_ALIGN).
  - If diff > MAX_ALIGN, small.frac is cleared to 0.
  - Go to ALIGN.
- **ALIGN**
  - If count==0, go to ADD.
  - Otherwise small.frac >>= 1 (zero fill) and count -= 1.
- **ADD** (1 cycle, FRAC_W+1-bit sum)
  - Same signs: sum = big.frac + small.frac.
    - On carry with exp<15: frac = sum[FRAC_W:1], exp+1.
    - On carry with exp==15: result = {big.sign, 15, all ones}, overflow=1, go straight to DONE.
  - Different signs: frac = big.frac - small.frac.
  - Result sign = big.sign. Go to NORM.
- **NORM**
  - frac==0: result = {0, 0, 0}, go to DONE.
  - Else if frac[MSB]==1 or exp==0: go to DONE (a subnormal result is left unshifted).
  - Otherwise frac <<= 1, exp -= 1, stay in NORM.
- **DONE**
  - `out_valid`=1; `result`/`overflow` are held stable.
  - On `out_ready`, go to IDLE.

## Timing
- Reset values: `in_ready`=0 while `rst_n` low and 1 from the first edge after release (state IDLE). `out_valid`=0, `result`=0, `overflow`=0, `busy`=0.
- Reset asserted mid-operation: immediate return to IDLE. The in-flight operation is discarded and all outputs are cleared.
- Latency, with c = alignment shifts and k = normalization shifts:
  - `out_valid` rises c+k+4 cycles after the accept edge.
  - Saturating-overflow path: c+3 cycles.
- Throughput: one operation in flight. `in_ready`=0 from the accept edge until the DONE handshake. The next accept is possible no earlier than the cycle after the `out_valid && out_ready` edge (the IDLE cycle).
- `out_valid`, once high, stays high with stable data until `out_ready` is sampled high. `out_ready` high before `out_valid` has no effect.
- `in_valid` outside IDLE is ignored. Operands are sampled only at the accept edge.

## Structure
- `FloatingPointPkg` holds:
  - `FRAC_W`.
  - `fp_t`.
  - The state enum `fpadd_state_t` {IDLE, COMPARE, ALIGN, ADD, NORM, DONE}.
  - `EXP_MAX` = 4'd15.
- Natural split: `fp_add_datapath`, which holds the operand/result registers, the 1-bit shifters, the adder/subtractor and the flags. It is driven by load/shift/add strobes from the FSM in `fp_add_controller`.

## Test plan
With FRAC_W=8:
- `a`={0,3,C0}, `b`={0,1,80}: c=2, sum E0 → `result`={0,3,E0}, `out_valid` 6 cycles after accept, `overflow`=0.
- `a`={0,2,80}, `b`={0,2,80}: carry → `result`={0,3,80}. Separately, `a`={0,15,80}, `b`={0,15,80} → `result`={0,15,FF}, `overflow`=1, latency 3.
- `a`={0,4,C0}, `b`={1,4,A0}: difference 20, k=2 → `result`={0,2,80}, latency 6. Separately, `a`={0,5,80}, `b`={1,5,80} → `result`={0,0,00}.
- `a`={1,1,FF}, `b`={0,12,90}: diff 11 > 8, small flushed, c=8 → `result`={0,12,90}, latency 12.
- `out_ready` held low 5 cycles in DONE → `out_valid` and `result` stable and `in_ready`=0 throughout. `in_valid` pulses during busy are ignored; the next accept occurs only in IDLE.
- `rst_n` pulsed low during ALIGN → outputs cleared at once, IDLE after release. A fresh operand pair then completes correctly.

Source files
------------

// File: rtl/fp_add_controller_pkg.sv
// ============================================================================
// Module  : FloatingPointPkg
// Brief   : Shared types and constants for the multi-cycle floating-point adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package FloatingPointPkg;

    localparam int FRAC_W = 8;
    localparam logic [3:0] EXP_MAX = 4'd15;

    // No hidden bit: value = (-1)^sign * frac * 2^exp
    typedef struct packed {
        logic              sign;
        logic [3:0]        exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        ALIGN   = 3'd2,
        ADD     = 3'd3,
        NORM    = 3'd4,
        DONE    = 3'd5
    } fpadd_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_add_controller_datapath.sv
// ============================================================================
// Module  : fp_add_datapath
// Brief   : Operand/result registers, 1-bit shifters and add/sub for fp_add.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_add_datapath
    import FloatingPointPkg::*;
#(
    parameter int MAX_ALIGN = FRAC_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic compare,
    input  logic align_shift,
    input  logic add,
    input  logic norm_shift,
    input  logic norm_zero,
    input  fp_t  a,
    input  fp_t  b,
    output logic count_zero,
    output logic add_ovf,
    output logic frac_zero,
    output logic frac_msb,
    output logic exp_zero,
    output fp_t  result,
    output logic overflow
);

    // A 4-bit exponent difference never exceeds 15, so larger caps behave as 15.
    localparam int         ALIGN_CAP   = (MAX_ALIGN > 15) ? 15 : MAX_ALIGN;
    localparam logic [3:0] c_align_cap = 4'(ALIGN_CAP);

    fp_t               r_a;
    fp_t               r_b;
    logic              r_sign;
    logic [3:0]        r_exp;
    logic [FRAC_W-1:0] r_frac;
    logic              r_small_sign;
    logic [FRAC_W-1:0] r_small;
    logic [3:0]        r_count;
    logic              r_ovf;

    logic              w_a_big;
    fp_t               w_big;
    fp_t               w_small;
    logic [3:0]        w_diff;
    logic              w_flush;
    logic              w_same;
    logic [FRAC_W:0]   w_sum;
    logic              w_carry;

    always_comb begin
        w_a_big = (r_a.exp > r_b.exp) ||
                  ((r_a.exp == r_b.exp) && (r_a.frac >= r_b.frac));
        w_big   = w_a_big ? r_a : r_b;
        w_small = w_a_big ? r_b : r_a;
        w_diff  = w_big.exp - w_small.exp;
        w_flush = w_diff > c_align_cap;
        w_same  = (r_sign == r_small_sign);
        w_sum   = w_same ? ({1'b0, r_frac} + {1'b0, r_small})
                         : ({1'b0, r_frac} - {1'b0, r_small});
        w_carry = w_same && w_sum[FRAC_W];
    end

    assign add_ovf    = w_carry && (r_exp == EXP_MAX);
    assign count_zero = (r_count == 4'd0);
    assign frac_zero  = (r_frac == '0);
    assign frac_msb   = r_frac[FRAC_W-1];
    assign exp_zero   = (r_exp == 4'd0);
    assign result     = '{sign: r_sign, exp: r_exp, frac: r_frac};
    assign overflow   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sign       <= 1'b0;
            r_exp        <= 4'd0;
            r_frac       <= '0;
            r_small_sign <= 1'b0;
            r_small      <= '0;
            r_count      <= 4'd0;
            r_ovf        <= 1'b0;
        end else if (load) begin
            r_a   <= a;
            r_b   <= b;
            r_ovf <= 1'b0;
        end else if (compare) begin
            r_sign       <= w_big.sign;
            r_exp        <= w_big.exp;
            r_frac       <= w_big.frac;
            r_small_sign <= w_small.sign;
            r_small      <= w_flush ? '0 : w_small.frac;
            r_count      <= w_flush ? c_align_cap : w_diff;
        end else if (align_shift) begin
            r_small <= r_small >> 1;
            r_count <= r_count - 4'd1;
        end else if (add) begin
            if (add_ovf) begin
                r_frac <= '1;
                r_ovf  <= 1'b1;
            end else if (w_carry) begin
                r_frac <= w_sum[FRAC_W:1];
                r_exp  <= r_exp + 4'd1;
            end else begin
                r_frac <= w_sum[FRAC_W-1:0];
            end
        end else if (norm_zero) begin
            r_sign <= 1'b0;
            r_exp  <= 4'd0;
            r_frac <= '0;
        end else if (norm_shift) begin
            r_frac <= r_frac << 1;
            r_exp  <= r_exp - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_add_controller.sv
// ============================================================================
// Module  : fp_add_controller
// Brief   : FSM sequencing compare/align/add/normalize over valid/ready ports.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_add_controller
    import FloatingPointPkg::*;
#(
    parameter int MAX_ALIGN = FRAC_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  fp_t  a,
    input  fp_t  b,
    output logic out_valid,
    input  logic out_ready,
    output fp_t  result,
    output logic overflow,
    output logic busy
);

    fpadd_state_t r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic w_load;
    logic w_compare;
    logic w_align_shift;
    logic w_add;
    logic w_norm_shift;
    logic w_norm_zero;
    logic w_count_zero;
    logic w_add_ovf;
    logic w_frac_zero;
    logic w_frac_msb;
    logic w_exp_zero;
    logic w_norm_done;

    always_comb begin
        w_norm_done   = w_frac_zero || w_frac_msb || w_exp_zero;
        w_load        = (r_state == IDLE) && in_valid && r_in_ready;
        w_compare     = (r_state == COMPARE);
        w_align_shift = (r_state == ALIGN) && !w_count_zero;
        w_add         = (r_state == ADD);
        w_norm_zero   = (r_state == NORM) && w_frac_zero;
        w_norm_shift  = (r_state == NORM) && !w_norm_done;
    end

    fp_add_datapath #(
        .MAX_ALIGN (MAX_ALIGN)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (w_load),
        .compare     (w_compare),
        .align_shift (w_align_shift),
        .add         (w_add),
        .norm_shift  (w_norm_shift),
        .norm_zero   (w_norm_zero),
        .a           (a),
        .b           (b),
        .count_zero  (w_count_zero),
        .add_ovf     (w_add_ovf),
        .frac_zero   (w_frac_zero),
        .frac_msb    (w_frac_msb),
        .exp_zero    (w_exp_zero),
        .result      (result),
        .overflow    (overflow)
    );

    // Handshake outputs are registered alongside the state so they change on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state    <= COMPARE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                COMPARE: r_state <= ALIGN;
                ALIGN: begin
                    if (w_count_zero) r_state <= ADD;
                end
                ADD: begin
                    if (w_add_ovf) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (w_norm_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_controller.sv
// ============================================================================
// Module  : tb_fp_add_controller
// Brief   : Directed self-checking bench for fp_add_controller (FRAC_W = 8).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_add_controller;
    import FloatingPointPkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    fp_t  a;
    fp_t  b;
    logic out_valid;
    logic out_ready;
    fp_t  result;
    logic overflow;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    fp_add_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic fp_t mk(input logic s, input logic [3:0] e, input logic [7:0] f);
        fp_t t;
        t.sign = s;
        t.exp  = e;
        t.frac = f;
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns edges from the accept edge until out_valid is seen high (40 = timeout).
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Called at a negedge with the block idle.
    task automatic run_op(input string tag, input fp_t op_a, input fp_t op_b,
                          input fp_t exp_res, input logic exp_ovf, input int lat,
                          input logic early_ready);
        int n;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (early_ready) out_ready = 1'b1;
        wait_out(n);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_busy_rdy"}, {30'd0, busy, in_ready}, 32'b10);
        handshake(tag);
    endtask

    initial begin
        int  n;
        fp_t held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {27'd0, in_ready, out_valid, overflow, busy, 1'b0}, 32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(in_ready), 32'd1);

        run_op("align2", mk(0, 3, 8'hC0), mk(0, 1, 8'h80), mk(0, 3, 8'hE0), 1'b0, 6, 1'b0);
        run_op("carry", mk(0, 2, 8'h80), mk(0, 2, 8'h80), mk(0, 3, 8'h80), 1'b0, 4, 1'b0);
        run_op("sat", mk(0, 15, 8'h80), mk(0, 15, 8'h80), mk(0, 15, 8'hFF), 1'b1, 3, 1'b1);
        run_op("sub_norm", mk(0, 4, 8'hC0), mk(1, 4, 8'hA0), mk(0, 2, 8'h80), 1'b0, 6, 1'b0);
        run_op("cancel", mk(0, 5, 8'h80), mk(1, 5, 8'h80), mk(0, 0, 8'h00), 1'b0, 4, 1'b0);
        run_op("flush", mk(1, 1, 8'hFF), mk(0, 12, 8'h90), mk(0, 12, 8'h90), 1'b0, 12, 1'b0);

        // Stall in DONE while in_valid stays high with new operands.
        a        = mk(0, 3, 8'hC0);
        b        = mk(0, 1, 8'h80);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = mk(0, 2, 8'h80);
        b = mk(0, 2, 8'h80);
        wait_out(n);
        check("stall_latency", 32'(n), 32'd6);
        check("stall_result0", 32'(result), 32'(mk(0, 3, 8'hE0)));
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'(result), 32'(held));
            check("stall_no_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_idle_cycle", {29'd0, out_valid, busy, in_ready}, 32'b001);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(n);
        check("next_latency", 32'(n), 32'd4);
        check("next_result", 32'(result), 32'(mk(0, 3, 8'h80)));
        handshake("next");

        // Asynchronous reset while shifting in ALIGN.
        a        = mk(1, 1, 8'hFF);
        b        = mk(0, 12, 8'h90);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {28'd0, in_ready, out_valid, overflow, busy}, 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {30'd0, busy, in_ready}, 32'b01);
        run_op("after_rst", mk(0, 4, 8'hC0), mk(1, 4, 8'hA0), mk(0, 2, 8'h80), 1'b0, 6, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
